// File: rtl/mac_result_drain.sv
// Result drain for mac_cluster: follows tagged final issues through the cluster latency,
// queues the captured outputs with their mode, and hands out issue credit so the queue never overruns.
module mac_result_drain #(
  parameter int ACC_W   = 32,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic                 issue_last,
  input  logic [1:0]           issue_mode,
  input  logic [ACC_W-1:0]     out0,
  input  logic [ACC_W-1:0]     out1,
  input  logic [ACC_W-1:0]     out2,
  input  logic [ACC_W-1:0]     out3,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*ACC_W-1:0]   res_data,
  output logic [1:0]           res_mode,
  output logic                 overflow,
  output logic [CNT_W-1:0]     result_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int IF_W  = $clog2(LATENCY + 1);
  localparam int CMP_W = PTR_W + IF_W + 1;
  localparam int ENT_W = 4 * ACC_W + 2;

  logic [LATENCY-1:0]   tag_cap_r;
  logic [1:0]           tag_mode_r [LATENCY];
  logic [ENT_W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [4*ACC_W-1:0]   res_data_r;
  logic [1:0]           res_mode_r;
  logic                 overflow_r;
  logic [CNT_W-1:0]     count_r;

  logic                 acc_s;
  logic                 ready_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 wr_en_s;
  logic [PTR_W-1:0]     fifo_cnt_s;
  logic [PTR_W-1:0]     wr_ptr_nxt_s;
  logic [PTR_W-1:0]     rd_ptr_nxt_s;
  logic [IF_W-1:0]      inflight_s;
  logic [ENT_W-1:0]     push_ent_s;
  logic [ENT_W-1:0]     head_nxt_s;
  logic                 head_load_s;

  assign empty_s      = (wr_ptr_r == rd_ptr_r);
  assign full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign fifo_cnt_s   = wr_ptr_r - rd_ptr_r;
  assign push_s       = tag_cap_r[LATENCY-1];
  assign pop_s        = !empty_s && res_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign wr_en_s      = push_s && (!full_s || pop_s);
  assign wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, wr_en_s};
  assign rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
  assign push_ent_s   = {tag_mode_r[LATENCY-1], out3, out2, out1, out0};

  assign ready_s      = (CMP_W'(fifo_cnt_s) + CMP_W'(inflight_s)) < CMP_W'(DEPTH);
  assign acc_s        = issue_valid && ready_s;

  assign issue_ready  = ready_s;
  assign res_valid    = !empty_s;
  assign res_data     = res_data_r;
  assign res_mode     = res_mode_r;
  assign overflow     = overflow_r;
  assign result_count = count_r;

  // Count tagged results still travelling through the cluster pipeline.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight_s = inflight_s + IF_W'(tag_cap_r[i]);
    end
  end

  // Next head entry, bypassing the write when the pushed entry becomes the head.
  always_comb begin
    head_load_s = 1'b0;
    head_nxt_s  = mem_r[rd_ptr_nxt_s[AW-1:0]];
    if (wr_ptr_nxt_s != rd_ptr_nxt_s) begin
      head_load_s = 1'b1;
      if (wr_en_s && (wr_ptr_r[AW-1:0] == rd_ptr_nxt_s[AW-1:0])) begin
        head_nxt_s = push_ent_s;
      end else begin
        head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
      end
    end else begin
      head_load_s = 1'b0;
    end
  end

  // Tag shift register mirroring the cluster latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_cap_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_mode_r[i] <= 2'd0;
      end
    end else begin
      tag_cap_r[0]  <= acc_s && issue_last;
      tag_mode_r[0] <= issue_mode;
      for (int i = 1; i < LATENCY; i++) begin
        tag_cap_r[i]  <= tag_cap_r[i-1];
        tag_mode_r[i] <= tag_mode_r[i-1];
      end
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_ent_s;
    end
  end

  // Pointers, head register, overflow flag and pop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      res_data_r <= '0;
      res_mode_r <= 2'd0;
      overflow_r <= 1'b0;
      count_r    <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      if (head_load_s) begin
        res_data_r <= head_nxt_s[4*ACC_W-1:0];
        res_mode_r <= head_nxt_s[ENT_W-1 -: 2];
      end
      if (push_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
      if (pop_s) begin
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed bench for mac_result_drain: a two-stage delay line stands in for mac_cluster,
// each scenario task checks its own hand-computed expectations.
module tb_mac_result_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic         issue_valid;
  logic         issue_ready;
  logic         issue_last;
  logic [1:0]   issue_mode;
  logic [31:0]  out0, out1, out2, out3;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic [1:0]   res_mode;
  logic         overflow;
  logic [3:0]   result_count;

  int           n_cmp = 0;
  int           n_fail = 0;
  logic [31:0]  cur_v = 32'd0;
  logic [31:0]  d0 = 32'd0;
  logic [31:0]  d1 = 32'd0;

  mac_result_drain #(.ACC_W(32), .LATENCY(2), .DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_last(issue_last), .issue_mode(issue_mode),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_mode(res_mode),
    .overflow(overflow), .result_count(result_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic logic [127:0] exp_word(input int b);
    logic [31:0] w;
    w = 32'(b);
    return {w + 32'd3, w + 32'd2, w + 32'd1, w};
  endfunction

  // Cluster model: outN = base+N, appearing two cycles after the base is presented.
  task automatic tick();
    @(posedge clk);
    d1 = d0;
    d0 = cur_v;
    #1;
    out0 = d1;
    out1 = d1 + 32'd1;
    out2 = d1 + 32'd2;
    out3 = d1 + 32'd3;
  endtask

  task automatic drive(input logic v, input logic last, input logic [1:0] mode, input int base);
    issue_valid = v;
    issue_last  = last;
    issue_mode  = mode;
    cur_v       = 32'(base);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    res_ready = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", issue_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", res_valid); end
    n_cmp++; if (res_data !== 128'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", res_data); end
    n_cmp++; if (res_mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d want 0", res_mode); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    n_cmp++; if (result_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", result_count); end
  endtask

  task automatic test_single_latency();
    do_reset();
    drive(1'b1, 1'b1, 2'd0, 5);
    tick();
    drive(1'b0, 1'b0, 2'd0, 0);
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_t1_valid: got %0b want 0", res_valid); end
    tick();
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_t2_valid: got %0b want 0", res_valid); end
    tick();
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL single_t3_valid: got %0b want 1", res_valid); end
    n_cmp++; if (res_data !== {32'd8, 32'd7, 32'd6, 32'd5}) begin n_fail++; $display("FAIL single_data: got %h want 8,7,6,5", res_data); end
    n_cmp++; if (res_mode !== 2'd0) begin n_fail++; $display("FAIL single_mode: got %0d want 0", res_mode); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_popped_valid: got %0b want 0", res_valid); end
    n_cmp++; if (result_count !== 4'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", result_count); end
  endtask

  task automatic test_accumulate();
    int waited;
    do_reset();
    drive(1'b1, 1'b0, 2'd1, 10); tick();
    drive(1'b1, 1'b0, 2'd1, 20); tick();
    drive(1'b1, 1'b1, 2'd1, 30); tick();
    drive(1'b0, 1'b0, 2'd0, 0);
    waited = 0;
    while (!res_valid && waited < 8) begin
      tick();
      waited++;
    end
    n_cmp++; if (waited !== 2) begin n_fail++; $display("FAIL acc_latency: got %0d cycles want 2", waited); end
    n_cmp++; if ({res_mode, res_data} !== {2'd1, exp_word(30)}) begin n_fail++; $display("FAIL acc_entry: got %0d/%h want 1/%h", res_mode, res_data, exp_word(30)); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL acc_single_entry: got valid %0b want 0", res_valid); end
    n_cmp++; if (result_count !== 4'd1) begin n_fail++; $display("FAIL acc_count: got %0d want 1", result_count); end
  endtask

  task automatic test_credit_stall();
    int n_acc;
    logic ready_at4;
    do_reset();
    n_acc = 0;
    ready_at4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, i[1:0], 100 + 16 * i);
      if (issue_ready) n_acc++;
      if (i == 4) ready_at4 = issue_ready;
      tick();
    end
    drive(1'b0, 1'b0, 2'd0, 0);
    tick(); tick(); tick();
    n_cmp++; if (n_acc !== 4) begin n_fail++; $display("FAIL stall_accepted: got %0d want 4", n_acc); end
    n_cmp++; if (ready_at4 !== 1'b0) begin n_fail++; $display("FAIL stall_ready_fall: got %0b want 0", ready_at4); end
    n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_full: got %0b want 0", issue_ready); end
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %0b want 1", res_valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL stall_overflow: got %0b want 0", overflow); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if ({res_mode, res_data} !== {2'd0, exp_word(100)}) begin n_fail++; $display("FAIL bp_hold_%0d: got %0d/%h want 0/%h", k, res_mode, res_data, exp_word(100)); end
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if ({res_valid, res_mode, res_data} !== {1'b1, k[1:0], exp_word(100 + 16 * k)}) begin n_fail++; $display("FAIL bp_drain_%0d: got %0b/%0d/%h want 1/%0d/%h", k, res_valid, res_mode, res_data, k, exp_word(100 + 16 * k)); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      if (k == 0) begin
        n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise: got %0b want 1", issue_ready); end
      end
    end
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %0b want 0", res_valid); end
    n_cmp++; if (result_count !== 4'd4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", result_count); end
  endtask

  task automatic test_full_push_pop();
    int exp_b [4];
    logic [1:0] exp_m [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 2'd0, 200 + 16 * i);
      tick();
    end
    drive(1'b0, 1'b0, 2'd0, 0);
    tick(); tick(); tick();
    n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL fpp_full_ready: got %0b want 0", issue_ready); end
    force dut.ready_s = 1'b1;
    drive(1'b1, 1'b1, 2'd2, 600);
    tick();
    release dut.ready_s;
    drive(1'b0, 1'b0, 2'd0, 0);
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_no_overflow: got %0b want 0", overflow); end
    n_cmp++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL fpp_still_full: got ready %0b want 0", issue_ready); end
    n_cmp++; if (res_data !== exp_word(216)) begin n_fail++; $display("FAIL fpp_head: got %h want %h", res_data, exp_word(216)); end
    n_cmp++; if (result_count !== 4'd1) begin n_fail++; $display("FAIL fpp_count: got %0d want 1", result_count); end
    force dut.ready_s = 1'b1;
    drive(1'b1, 1'b1, 2'd3, 700);
    tick();
    release dut.ready_s;
    drive(1'b0, 1'b0, 2'd0, 0);
    tick();
    tick();
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fpp_overflow_set: got %0b want 1", overflow); end
    tick(); tick();
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fpp_overflow_sticky: got %0b want 1", overflow); end
    exp_b[0] = 216; exp_b[1] = 232; exp_b[2] = 248; exp_b[3] = 600;
    exp_m[0] = 2'd0; exp_m[1] = 2'd0; exp_m[2] = 2'd0; exp_m[3] = 2'd2;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if ({res_valid, res_mode, res_data} !== {1'b1, exp_m[k], exp_word(exp_b[k])}) begin n_fail++; $display("FAIL fpp_drain_%0d: got %0b/%0d/%h want 1/%0d/%h", k, res_valid, res_mode, res_data, exp_m[k], exp_word(exp_b[k])); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_dropped_absent: got %0b want 0", res_valid); end
  endtask

  task automatic test_midop_reset();
    int stale;
    do_reset();
    drive(1'b1, 1'b1, 2'd0, 900); tick();
    drive(1'b0, 1'b0, 2'd0, 0); tick(); tick();
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 2'd1, 800 + 16 * i);
      tick();
    end
    drive(1'b0, 1'b0, 2'd0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %0b want 0", res_valid); end
    n_cmp++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %0b want 1", issue_ready); end
    n_cmp++; if (result_count !== 4'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", result_count); end
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (res_valid) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_fail++; $display("FAIL mid_stale: got %0d valid cycles want 0", stale); end
  endtask

  task automatic test_wrap();
    int issued;
    int popped;
    do_reset();
    res_ready = 1'b1;
    issued = 0;
    popped = 0;
    for (int c = 0; c < 80 && popped < 17; c++) begin
      if (issued < 17) drive(1'b1, 1'b1, issued[1:0], 1000 + 4 * issued);
      else drive(1'b0, 1'b0, 2'd0, 0);
      if (res_valid) begin
        n_cmp++; if ({res_mode, res_data} !== {popped[1:0], exp_word(1000 + 4 * popped)}) begin n_fail++; $display("FAIL wrap_pop_%0d: got %0d/%h want %0d/%h", popped, res_mode, res_data, popped[1:0], exp_word(1000 + 4 * popped)); end
        popped++;
      end
      if (issue_valid && issue_ready) issued++;
      tick();
    end
    res_ready = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 0);
    n_cmp++; if (popped !== 17) begin n_fail++; $display("FAIL wrap_popped: got %0d want 17", popped); end
    n_cmp++; if (result_count !== 4'd1) begin n_fail++; $display("FAIL wrap_count: got %0d want 1", result_count); end
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %0b want 0", res_valid); end
  endtask

  initial begin
    rst = 1'b1;
    res_ready = 1'b0;
    issue_valid = 1'b0;
    issue_last = 1'b0;
    issue_mode = 2'd0;
    out0 = 32'd0; out1 = 32'd0; out2 = 32'd0; out3 = 32'd0;
    test_reset();
    test_single_latency();
    test_accumulate();
    test_credit_stall();
    test_backpressure();
    test_full_push_pop();
    test_midop_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
